// File: rtl/regfile_branch_unit_if.sv
// Bundle of register-file read/write ports and branch-decision signals
// shared by decode, the ULA and the PC logic.
interface regfile_branch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
);
  logic [4:0]            reg1;
  logic [4:0]            reg2;
  logic [4:0]            reg_escrita;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] escreve_dado;
  logic                  clear_offset_base;
  logic [DATA_WIDTH-1:0] dado1;
  logic [DATA_WIDTH-1:0] dado2;
  logic [DATA_WIDTH-1:0] fp;
  logic [DATA_WIDTH-1:0] s0;
  logic [DATA_WIDTH-1:0] offset_base;
  logic                  beq;
  logic                  bne;
  logic                  zero;
  logic                  control_branch;
  logic [DATA_WIDTH-1:0] imediato;
  logic [ADDR_WIDTH-1:0] pc_atual;
  logic [ADDR_WIDTH-1:0] novo_endereco;

  // No valid/ready handshake: reg_write and clear_offset_base are sampled on
  // the rising edge; every output is combinational from inputs and state.
  modport master (
    output reg1, reg2, reg_escrita, reg_write, escreve_dado, clear_offset_base,
    output beq, bne, zero, imediato, pc_atual,
    input  dado1, dado2, fp, s0, offset_base, control_branch, novo_endereco
  );

  modport slave (
    input  reg1, reg2, reg_escrita, reg_write, escreve_dado, clear_offset_base,
    input  beq, bne, zero, imediato, pc_atual,
    output dado1, dado2, fp, s0, offset_base, control_branch, novo_endereco
  );
endinterface

// File: rtl/regfile_branch_unit.sv
// 32-entry register file with $fp/$s0/offset-base taps, plus the BEQ/BNE
// decision and next-PC adder of the single-cycle datapath.
module regfile_branch_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_ADDR_WIDTH = 13,
  parameter int ADDR_WIDTH      = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_branch_unit_if.slave  bus
);
  localparam int REG_FP     = 30;
  localparam int REG_S0     = 16;
  localparam int REG_OFFSET = 24;

  logic [DATA_WIDTH-1:0] r_regs [32];

  logic                       w_branch;
  logic [ADDR_WIDTH-1:0]      w_seq;
  logic [ADDR_WIDTH-1:0]      w_target;
  logic [DATA_ADDR_WIDTH-1:0] w_unused_daddr;
  logic [DATA_WIDTH-1:0]      w_unused_imm;

  // Clear of the offset base is applied after the write so it wins on reg 24.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (bus.reg_write && (bus.reg_escrita != 5'd0)) begin
        r_regs[bus.reg_escrita] <= bus.escreve_dado;
      end
      if (bus.clear_offset_base) begin
        r_regs[REG_OFFSET] <= '0;
      end
    end
  end

  assign bus.dado1       = (bus.reg1 == 5'd0) ? '0 : r_regs[bus.reg1];
  assign bus.dado2       = (bus.reg2 == 5'd0) ? '0 : r_regs[bus.reg2];
  assign bus.fp          = r_regs[REG_FP];
  assign bus.s0          = r_regs[REG_S0];
  assign bus.offset_base = r_regs[REG_OFFSET];

  assign w_branch = (bus.beq & bus.zero) | (bus.bne & ~bus.zero);
  assign bus.control_branch = w_branch;

  // Only the low ADDR_WIDTH immediate bits form the offset; the sum wraps.
  assign w_seq    = bus.pc_atual + ADDR_WIDTH'(1);
  assign w_target = w_seq + bus.imediato[ADDR_WIDTH-1:0];
  assign bus.novo_endereco = w_branch ? w_target : w_seq;

  assign w_unused_daddr = '0;
  assign w_unused_imm   = bus.imediato;
endmodule

// File: tb/tb_regfile_branch_unit.sv
// Self-checking bench for regfile_branch_unit: directed literal checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_regfile_branch_unit;
  localparam int DW = 32;
  localparam int AW = 13;

  logic clock;
  logic reset;
  logic check_en;

  int n_cmp;
  int n_bad;

  logic [DW-1:0] model_regs [32];
  logic [DW-1:0] exp_q [$];

  regfile_branch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_branch_unit #(
    .DATA_WIDTH(DW), .DATA_ADDR_WIDTH(13), .ADDR_WIDTH(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // model: architectural register state updated with the edge rules
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = '0;
    end else begin
      if (bus.reg_write && bus.reg_escrita != 5'd0) model_regs[bus.reg_escrita] = bus.escreve_dado;
      if (bus.clear_offset_base) model_regs[24] = '0;
    end
  end

  function automatic logic [DW-1:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? '0 : model_regs[a];
  endfunction

  function automatic bit model_taken();
    return (bus.beq && bus.zero) || (bus.bne && !bus.zero);
  endfunction

  function automatic logic [AW-1:0] model_next_pc();
    int unsigned seq;
    int unsigned off;
    seq = (int'(bus.pc_atual) + 1) % 8192;
    off = model_taken() ? (bus.imediato % 8192) : 0;
    return AW'((seq + off) % 8192);
  endfunction

  // scoreboard compare on the falling edge
  always @(negedge clock) begin
    if (check_en) begin
      check("dado1", bus.dado1, model_read(bus.reg1));
      check("dado2", bus.dado2, model_read(bus.reg2));
      check("fp", bus.fp, model_regs[30]);
      check("s0", bus.s0, model_regs[16]);
      check("offset_base", bus.offset_base, model_regs[24]);
      check("control_branch", DW'(bus.control_branch), DW'(model_taken()));
      check("novo_endereco", DW'(bus.novo_endereco), DW'(model_next_pc()));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.reg1 = '0; bus.reg2 = '0; bus.reg_escrita = '0; bus.reg_write = 1'b0;
    bus.escreve_dado = '0; bus.clear_offset_base = 1'b0;
    bus.beq = 1'b0; bus.bne = 1'b0; bus.zero = 1'b0;
    bus.imediato = '0; bus.pc_atual = '0;
  endtask

  task automatic set_write(input logic [4:0] a, input logic [DW-1:0] d);
    bus.reg_write = 1'b1; bus.reg_escrita = a; bus.escreve_dado = d;
  endtask

  task automatic set_branch(input logic b_eq, input logic b_ne, input logic z,
                            input logic [AW-1:0] pc, input logic [DW-1:0] imm);
    bus.beq = b_eq; bus.bne = b_ne; bus.zero = z; bus.pc_atual = pc; bus.imediato = imm;
    #1;
  endtask

  // literal expectation via queue: push expected, pop and compare
  task automatic lit(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    logic [DW-1:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    check(name, act, e);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; check_en = 1'b0;
    drive_idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check_en = 1'b1;

    // every address reads zero after reset
    for (int a = 0; a < 32; a++) begin
      bus.reg1 = 5'(a); bus.reg2 = 5'(31 - a);
      #1;
      lit("rst_dado1", bus.dado1, 32'h0);
      lit("rst_dado2", bus.dado2, 32'h0);
      tick();
    end
    lit("rst_fp", bus.fp, 32'h0);
    lit("rst_s0", bus.s0, 32'h0);
    lit("rst_offset_base", bus.offset_base, 32'h0);

    // taps; same-cycle read shows the old value
    set_write(5'd30, 32'hDEADBEEF); bus.reg1 = 5'd30;
    #1;
    lit("old_dado1_r30", bus.dado1, 32'h0);
    lit("old_fp", bus.fp, 32'h0);
    tick();
    lit("new_fp", bus.fp, 32'hDEADBEEF);
    lit("new_dado1_r30", bus.dado1, 32'hDEADBEEF);
    set_write(5'd16, 32'h12345678);
    tick();
    set_write(5'd24, 32'h00000100);
    tick();
    bus.reg_write = 1'b0;
    #1;
    lit("new_s0", bus.s0, 32'h12345678);
    lit("new_offset_base", bus.offset_base, 32'h00000100);

    // register 0 ignores writes
    set_write(5'd0, 32'hFFFFFFFF); bus.reg1 = 5'd0;
    tick();
    bus.reg_write = 1'b0;
    #1;
    lit("r0_zero", bus.dado1, 32'h0);

    // clear beats a same-edge write to reg 24
    set_write(5'd24, 32'h55); bus.clear_offset_base = 1'b1;
    tick();
    bus.reg_write = 1'b0; bus.clear_offset_base = 1'b0;
    #1;
    lit("clear_prio", bus.offset_base, 32'h0);

    // reset beats a same-edge write
    set_write(5'd5, 32'hAA); bus.reg1 = 5'd5;
    tick();
    bus.reg_write = 1'b0;
    #1;
    lit("r5_written", bus.dado1, 32'hAA);
    set_write(5'd5, 32'h77); reset = 1'b1;
    tick();
    reset = 1'b0; bus.reg_write = 1'b0;
    #1;
    lit("reset_prio_r5", bus.dado1, 32'h0);
    lit("reset_prio_fp", bus.fp, 32'h0);

    // branch decision and target
    tick();
    set_branch(1'b1, 1'b0, 1'b1, 13'd10, 32'd5);
    lit("beq_taken_cb", DW'(bus.control_branch), 32'd1);
    lit("beq_taken_pc", DW'(bus.novo_endereco), 32'd16);
    set_branch(1'b1, 1'b0, 1'b0, 13'd10, 32'd5);
    lit("beq_not_cb", DW'(bus.control_branch), 32'd0);
    lit("beq_not_pc", DW'(bus.novo_endereco), 32'd11);
    set_branch(1'b0, 1'b1, 1'b0, 13'd10, 32'd5);
    lit("bne_taken_cb", DW'(bus.control_branch), 32'd1);
    lit("bne_taken_pc", DW'(bus.novo_endereco), 32'd16);
    tick();
    set_branch(1'b1, 1'b1, 1'b1, 13'd10, 32'd5);
    lit("both_cb", DW'(bus.control_branch), 32'd1);
    set_branch(1'b0, 1'b0, 1'b1, 13'h1FFF, 32'd7);
    lit("wrap_seq_cb", DW'(bus.control_branch), 32'd0);
    lit("wrap_seq_pc", DW'(bus.novo_endereco), 32'h0);
    set_branch(1'b1, 1'b0, 1'b1, 13'd20, 32'hABCDFFFB);
    lit("neg_off_pc", DW'(bus.novo_endereco), 32'd16);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      bus.reg1 = 5'($urandom_range(0, 31));
      bus.reg2 = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 5))
        0: bus.reg_escrita = 5'd24;
        1: bus.reg_escrita = 5'd0;
        2: bus.reg_escrita = ($urandom_range(0, 1) != 0) ? 5'd16 : 5'd30;
        default: bus.reg_escrita = 5'($urandom_range(0, 31));
      endcase
      bus.reg_write = 1'($urandom_range(0, 1));
      bus.escreve_dado = $urandom;
      bus.clear_offset_base = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 99) == 0);
      bus.beq = 1'($urandom_range(0, 1));
      bus.bne = 1'($urandom_range(0, 1));
      bus.zero = 1'($urandom_range(0, 1));
      bus.imediato = $urandom;
      bus.pc_atual = ($urandom_range(0, 9) == 0) ? 13'h1FFF : 13'($urandom);
    end
    tick();
    reset = 1'b0;
    drive_idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_branch_unit.md
# regfile_branch_unit

Register file plus branch-decision and branch-target logic for the single-cycle CPU datapath. It provides two combinational read ports and one clocked write port over 32 general registers, taps three architecturally special registers ($fp, $s0, offset base $24), and computes the next sequential/branch PC from the current PC, the 32-bit extended immediate and the ALU zero flag. It sits between instruction decode, the ULA and the PC/offset-base logic.

## Interface
Parameters:
- DATA_WIDTH, 32, register and immediate width
- DATA_ADDR_WIDTH, 13, data-memory address width (carried for consistency; no functional effect)
- ADDR_WIDTH, 13, instruction address / PC width

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- reg1  in  5  read address port 1 (instr[25:21])
- reg2  in  5  read address port 2 (instr[20:16])
- reg_escrita  in  5  write address
- reg_write  in  1  write enable
- escreve_dado  in  DATA_WIDTH  write data
- clear_offset_base  in  1  zero register 24 on this edge
- dado1  out  DATA_WIDTH  contents of reg1
- dado2  out  DATA_WIDTH  contents of reg2
- fp  out  DATA_WIDTH  contents of register 30
- s0  out  DATA_WIDTH  contents of register 16
- offset_base  out  DATA_WIDTH  contents of register 24
- beq  in  1  current instruction is BEQ
- bne  in  1  current instruction is BNE
- zero  in  1  ULA zero flag (operands equal)
- control_branch  out  1  branch taken
- imediato  in  DATA_WIDTH  extended immediate (signed offset in low ADDR_WIDTH bits)
- pc_atual  in  ADDR_WIDTH  current PC
- novo_endereco  out  ADDR_WIDTH  next PC (sequential or branch target)

## Operation
- Storage: 32 registers of DATA_WIDTH bits.
- Register 0 reads as 0 always; writes to address 0 are discarded.
- Reads: dado1/dado2/fp/s0/offset_base are purely combinational from the stored array; no write-to-read bypass.
- Write: on rising clock, if reg_write and reg_escrita != 0, register[reg_escrita] <= escreve_dado.
- clear_offset_base: on rising clock, register 24 <= 0; takes priority over a same-cycle write to register 24. Writes to other registers in the same cycle proceed normally.
- Reset (highest priority): on rising clock with reset=1, all 32 registers <= 0; writes and clear ignored that cycle.
- Branch decision: control_branch = (beq & zero) | (bne & ~zero). beq and bne both high: OR of both terms (i.e. always taken); both low: 0.
- Branch target: seq = pc_atual + 1; novo_endereco = control_branch ? seq + imediato[ADDR_WIDTH-1:0] : seq. Arithmetic is ADDR_WIDTH bits, modulo 2^ADDR_WIDTH (wrap, no overflow flag); negative offsets work via two's-complement wrap.
- The branch adder uses the internally computed control_branch (no separate mux input).

## Timing
- Read paths, control_branch and novo_endereco: zero-cycle combinational from inputs and current register state.
- Write latency: data visible on dado1/dado2/taps immediately after the rising edge that captures it (next cycle's reads).
- Reset values: all registers 0, hence dado1, dado2, fp, s0, offset_base = 0 after reset; control_branch and novo_endereco depend only on current inputs (no reset state).
- No handshakes; reg_write, clear_offset_base and reset are sampled only at rising edge.

## Test plan
- Reset then read all addresses -> every dado1/dado2 = 0, fp = s0 = offset_base = 0.
- Write 0xDEADBEEF to reg 30, 0x12345678 to reg 16, 0x100 to reg 24 -> fp = 0xDEADBEEF, s0 = 0x12345678, offset_base = 0x100 from next cycle; same-cycle read of the target shows old value.
- Write 0xFFFFFFFF to reg 0 -> dado1 with reg1=0 stays 0.
- Same edge: reg_write to reg 24 with 0x55 and clear_offset_base=1 -> offset_base = 0; repeat with reset=1 and write to reg 5 -> reg 5 = 0.
- beq=1, zero=1, pc_atual=10, imediato=5 -> control_branch=1, novo_endereco=16; zero=0 -> 0, 11; bne=1, zero=0 -> 1, 16.
- Wrap: pc_atual=0x1FFF, no branch -> novo_endereco=0x0000; pc_atual=20, branch taken, imediato=0x1FFB (-5) -> 16.
